// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the command-driven counter controller.
// Imported by the controller and its interface users.
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_START  = 2'd0,
    CMD_PAUSE  = 2'd1,
    CMD_RESUME = 2'd2,
    CMD_ABORT  = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic DIR_UP        = 1'b1;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/cnt_ctrl_if.sv
// Command and status bundle for cnt_ctrl.
// Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
// cmd_ready depends only on controller state, never on cmd_valid.
interface cnt_ctrl_if #(
  parameter int W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic         cmd_dir;
  logic         cmd_mode;
  logic [W-1:0] cmd_limit;
  logic [W-1:0] cnt;
  logic         busy;
  logic         tc_pulse;
  logic         done;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_mode, cmd_limit,
    input  cmd_ready, cnt, busy, tc_pulse, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_mode, cmd_limit,
    output cmd_ready, cnt, busy, tc_pulse, done
  );
endinterface

// File: rtl/cnt_ctrl_core.sv
// Loadable up/down counter register driven by the cnt_ctrl sequencer.
// Load has priority over a count step.
module cnt_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= dir ? cnt + W'(1) : cnt - W'(1);
    end
  end

endmodule

// File: rtl/cnt_ctrl.sv
// Command sequencer for an up/down counter: FSM, latched run configuration
// and terminal compare; the counter register itself lives in cnt_core.
module cnt_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  cnt_ctrl_if.slave   bus,
  output state_t      dbg_state
);

  state_t       state, state_next;
  logic         cfg_dir, cfg_mode;
  logic [W-1:0] cfg_limit;
  logic         tc_pulse_r, done_r, tc_next, done_next;
  logic         latch_cfg, core_load, core_en;
  logic [W-1:0] core_load_val, cnt, term_val, reload_val, start_val;
  logic         accept, at_term;
  cmd_op_t      op;

  assign op         = cmd_op_t'(bus.cmd_op);
  assign accept     = bus.cmd_valid && bus.cmd_ready;
  assign term_val   = (cfg_dir == DIR_UP) ? cfg_limit : '0;
  assign reload_val = (cfg_dir == DIR_UP) ? '0 : cfg_limit;
  assign start_val  = (bus.cmd_dir == DIR_UP) ? '0 : bus.cmd_limit;
  assign at_term    = (cnt == term_val);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cfg_dir    <= 1'b0;
      cfg_mode   <= 1'b0;
      cfg_limit  <= '0;
      tc_pulse_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state      <= state_next;
      tc_pulse_r <= tc_next;
      done_r     <= done_next;
      if (latch_cfg) begin
        cfg_dir   <= bus.cmd_dir;
        cfg_mode  <= bus.cmd_mode;
        cfg_limit <= bus.cmd_limit;
      end
    end
  end

  // START and ABORT win over anything the current state would do,
  // including a terminal count landing on the same edge.
  always_comb begin
    state_next    = state;
    latch_cfg     = 1'b0;
    core_load     = 1'b0;
    core_load_val = '0;
    core_en       = 1'b0;
    tc_next       = 1'b0;
    done_next     = 1'b0;
    if (accept && op == CMD_START) begin
      latch_cfg     = 1'b1;
      core_load     = 1'b1;
      core_load_val = start_val;
      state_next    = S_RUN;
    end else if (accept && op == CMD_ABORT) begin
      core_load  = 1'b1;
      state_next = S_IDLE;
    end else begin
      case (state)
        S_RUN: begin
          if (accept && op == CMD_PAUSE) begin
            state_next = S_HOLD;
          end else if (at_term) begin
            tc_next = 1'b1;
            if (cfg_mode == MODE_PERIODIC) begin
              core_load     = 1'b1;
              core_load_val = reload_val;
            end else begin
              done_next  = 1'b1;
              state_next = S_DONE;
            end
          end else begin
            core_en = 1'b1;
          end
        end
        S_HOLD: if (accept && op == CMD_RESUME) state_next = S_RUN;
        S_DONE: state_next = S_IDLE;
        default: ;
      endcase
    end
  end

  cnt_core #(.W(W)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (core_load),
    .load_val (core_load_val),
    .en       (core_en),
    .dir      (cfg_dir),
    .cnt      (cnt)
  );

  assign bus.cnt       = cnt;
  assign bus.busy      = (state == S_RUN) || (state == S_HOLD);
  assign bus.cmd_ready = (state != S_DONE);
  assign bus.tc_pulse  = tc_pulse_r;
  assign bus.done      = done_r;
  assign dbg_state     = state;

`ifdef ASSERTS_SV
  a_done_tc: assert property (@(posedge clk) disable iff (!rst_n)
    done_r |-> tc_pulse_r);
  a_step: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_RUN && !accept && !at_term) |=>
      (cnt == $past(cnt) + W'(1) || cnt == $past(cnt) - W'(1)));
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_HOLD) |-> $stable(cnt));
  a_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({cnt, bus.busy, bus.cmd_ready}));
`endif

endmodule

// File: tb/tb_cnt_ctrl.sv
// Scoreboard bench for cnt_ctrl: a behavioural model predicts the outputs
// after every edge; a negedge monitor pops and compares them.
module tb_cnt_ctrl;
  localparam int W  = 8;
  localparam int EW = W + 4;
  localparam logic [1:0] OP_START = 2'd0, OP_PAUSE = 2'd1, OP_RESUME = 2'd2, OP_ABORT = 2'd3;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cnt_ctrl_if #(.W(W)) bus();
  cnt_ctrl_pkg::state_t dbg_state;

  cnt_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // scoreboard: {cnt, busy, tc_pulse, done, cmd_ready}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp, mon_got;
  int checks = 0;
  int failures = 0;
  int cycle_no = 0;
  int mon_no = 0;

  // reference model state
  int m_st = M_IDLE;
  int m_cnt = 0;
  int m_lim = 0;
  bit m_dir = 1'b0;
  bit m_mode = 1'b0;

  task automatic model_edge(input bit rst_lv, input bit v, input logic [1:0] op,
                            input bit dir, input bit mode, input int lim,
                            output logic [EW-1:0] e);
    bit acc, tc, dn;
    int term;
    tc = 1'b0;
    dn = 1'b0;
    acc = v && (m_st != M_DONE);
    if (!rst_lv) begin
      m_st = M_IDLE; m_cnt = 0; m_dir = 1'b0; m_mode = 1'b0; m_lim = 0;
    end else if (acc && op == OP_START) begin
      m_dir = dir; m_mode = mode; m_lim = lim;
      m_cnt = dir ? 0 : lim;
      m_st = M_RUN;
    end else if (acc && op == OP_ABORT) begin
      m_st = M_IDLE; m_cnt = 0;
    end else if (m_st == M_DONE) begin
      m_st = M_IDLE;
    end else if (m_st == M_HOLD) begin
      if (acc && op == OP_RESUME) m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (acc && op == OP_PAUSE) begin
        m_st = M_HOLD;
      end else begin
        term = m_dir ? m_lim : 0;
        if (m_cnt != term) begin
          m_cnt = (m_cnt + (m_dir ? 1 : (1 << W) - 1)) % (1 << W);
        end else begin
          tc = 1'b1;
          if (m_mode) m_cnt = m_dir ? 0 : m_lim;
          else begin
            dn = 1'b1;
            m_st = M_DONE;
          end
        end
      end
    end
    e = {W'(m_cnt), (m_st == M_RUN || m_st == M_HOLD), tc, dn, (m_st != M_DONE)};
  endtask

  // driver tasks
  task automatic cycle(input bit rst_lv, input bit v, input logic [1:0] op,
                       input bit dir, input bit mode, input logic [W-1:0] lim);
    logic [EW-1:0] e;
    rst_n         = rst_lv;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_dir   = dir;
    bus.cmd_mode  = mode;
    bus.cmd_limit = lim;
    model_edge(rst_lv, v, op, dir, mode, int'(lim), e);
    @(posedge clk);
    exp_q.push_back(e);
    cycle_no++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, OP_START, 1'b0, 1'b0, '0);
  endtask

  task automatic cmd(input logic [1:0] op, input bit dir = 1'b0, input bit mode = 1'b0,
                     input int lim = 0);
    cycle(1'b1, 1'b1, op, dir, mode, W'(lim));
  endtask

  task automatic wait_cnt(input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < 300) begin
      idle(1);
      n++;
    end
    if (m_cnt != target) begin
      checks++;
      failures++;
      $display("FAIL wait_cnt: count %0d never reached %0d", m_cnt, target);
    end
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_got = {bus.cnt, bus.busy, bus.tc_pulse, bus.done, bus.cmd_ready};
        checks++;
        mon_no++;
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL outputs edge %0d: got cnt=%0d busy=%b tc=%b done=%b ready=%b (state %0d), expected cnt=%0d busy=%b tc=%b done=%b ready=%b",
                   mon_no, mon_got[EW-1:4], mon_got[3], mon_got[2], mon_got[1], mon_got[0], dbg_state,
                   mon_exp[EW-1:4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  // stimulus
  int r;
  initial begin
    cycle(1'b0, 1'b0, OP_START, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, OP_START, 1'b0, 1'b0, '0);
    idle(2);

    // one-shot up to 3
    cmd(OP_START, 1'b1, 1'b0, 3);
    idle(8);
    // periodic down from 2
    cmd(OP_START, 1'b0, 1'b1, 2);
    idle(9);
    cmd(OP_ABORT);
    // pause / resume mid-run
    cmd(OP_START, 1'b1, 1'b0, 10);
    wait_cnt(4);
    cmd(OP_PAUSE);
    idle(5);
    cmd(OP_PAUSE);
    cmd(OP_RESUME);
    idle(12);
    // abort on the terminal cycle, then a short run
    cmd(OP_START, 1'b1, 1'b1, 5);
    wait_cnt(5);
    cmd(OP_ABORT);
    idle(2);
    cmd(OP_START, 1'b1, 1'b0, 1);
    idle(5);
    // limit zero, periodic then one-shot; commands offered during DONE are refused
    cmd(OP_START, 1'b1, 1'b1, 0);
    idle(5);
    cmd(OP_START, 1'b1, 1'b0, 0);
    idle(4);
    cmd(OP_START, 1'b1, 1'b0, 0);
    idle(1);
    cmd(OP_START, 1'b1, 1'b1, 7);
    idle(2);
    cmd(OP_RESUME);
    cmd(OP_PAUSE);
    // reset mid-run
    cmd(OP_START, 1'b1, 1'b1, 200);
    wait_cnt(50);
    cycle(1'b0, 1'b0, OP_START, 1'b0, 1'b0, '0);
    idle(3);
    // commands landing on the terminal cycle
    cmd(OP_START, 1'b1, 1'b1, 3);
    wait_cnt(3);
    cmd(OP_PAUSE);
    idle(2);
    cmd(OP_RESUME);
    wait_cnt(3);
    cmd(OP_RESUME);
    wait_cnt(3);
    cmd(OP_START, 1'b0, 1'b1, 4);
    idle(6);
    cmd(OP_START, 1'b0, 1'b0, 2);
    idle(6);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        cycle(1'b0, 1'b0, OP_START, 1'b0, 1'b0, '0);
      end else if (r < 30) begin
        cycle(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 5)));
      end else begin
        idle(1);
      end
    end
    idle(2);

    repeat (20) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
